// File: rtl/alu_mc_pkg.sv
// Shared encodings for the multi-cycle ALU: base ops, M ops, FSM states.
// Holds the iteration-counter width helper used by the datapath.
package alu_mc_pkg;

  localparam int N_DEF = 32;
  localparam int CNT_W = $clog2(N_DEF) + 1;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SLL  = 4'd1,
    OP_SLT  = 4'd2,
    OP_SLTU = 4'd3,
    OP_XOR  = 4'd4,
    OP_SRL  = 4'd5,
    OP_OR   = 4'd6,
    OP_AND  = 4'd7,
    OP_SUB  = 4'd8,
    OP_LUI  = 4'd9,
    OP_SRA  = 4'd13
  } base_op_t;

  typedef enum logic [2:0] {
    M_MUL    = 3'd0,
    M_MULH   = 3'd1,
    M_MULHSU = 3'd2,
    M_MULHU  = 3'd3,
    M_DIV    = 3'd4,
    M_DIVU   = 3'd5,
    M_REM    = 3'd6,
    M_REMU   = 3'd7
  } m_op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BASE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/iter_muldiv_nb.sv
// Shared N-step datapath: shift-add multiply or restoring divide on magnitudes.
// Ports: clk, rst (sync, high), load, mode (0 mul / 1 div), a, b, run, last, acc.
import alu_mc_pkg::*;

module iter_muldiv_nb #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           mode,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           run,
  output logic           last,
  output logic [2*N-1:0] acc
);

  localparam int CW = cnt_w(N);

  logic [CW-1:0] cnt;
  logic          mode_q;
  logic [N-1:0]  op_q;

  // mul: acc = {partial, multiplier}; add multiplicand when lsb set
  logic [N:0] sum;
  assign sum = {1'b0, acc[2*N-1:N]}
             + (acc[0] ? {1'b0, op_q} : '0);

  // div: acc = {remainder, dividend/quotient}
  logic [N:0]   trial;
  logic [N:0]   diff;
  logic         qbit;
  logic [N-1:0] rem_nx;
  assign trial  = {acc[2*N-1:N], acc[N-1]};
  assign diff   = trial - {1'b0, op_q};
  assign qbit   = ~diff[N];
  assign rem_nx = qbit ? diff[N-1:0] : trial[N-1:0];

  assign last = run && (cnt == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      cnt    <= '0;
      run    <= 1'b0;
      mode_q <= 1'b0;
      op_q   <= '0;
    end else if (load) begin
      acc    <= {{N{1'b0}}, (mode ? a : b)};
      op_q   <= mode ? b : a;
      mode_q <= mode;
      cnt    <= '0;
      run    <= 1'b1;
    end else if (run) begin
      if (mode_q)
        acc <= {rem_nx, acc[N-2:0], qbit};
      else
        acc <= {sum, acc[N-1:1]};
      cnt <= cnt + 1'b1;
      if (last)
        run <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc_nb.sv
// Multi-cycle RV32I/M ALU with start/busy/done handshake; FSM, base ALU, FIX.
// Ports: CLK, RST, start, m_op, alu_fun, srcA, srcB -> result, busy, done.
// Macro ALU_MC_EARLY_OUT_EN: skip iterations for trivially known M results.
import alu_mc_pkg::*;

module alu_mc_nb #(
  parameter int N = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic         m_op,
  input  logic [3:0]   alu_fun,
  input  logic [N-1:0] srcA,
  input  logic [N-1:0] srcB,
  output logic [N-1:0] result,
  output logic         busy,
  output logic         done
);

  localparam int SW = $clog2(N);

  state_t       state;
  logic [N-1:0] a_q;
  logic [N-1:0] b_q;
  logic [3:0]   fun_q;
  logic [2:0]   mf;

  assign mf = fun_q[2:0];

  logic [N-1:0] min_v;
  assign min_v = {1'b1, {(N-1){1'b0}}};

  // ---- base ALU ----
  logic [SW-1:0] shamt;
  logic [N-1:0]  base_res;
  assign shamt = b_q[SW-1:0];

  always_comb begin
    base_res = '0;
    case (fun_q)
      OP_ADD:  base_res = a_q + b_q;
      OP_SLL:  base_res = a_q << shamt;
      OP_SLT:  base_res = {{(N-1){1'b0}},
                           $signed(a_q) < $signed(b_q)};
      OP_SLTU: base_res = {{(N-1){1'b0}}, a_q < b_q};
      OP_XOR:  base_res = a_q ^ b_q;
      OP_SRL:  base_res = a_q >> shamt;
      OP_OR:   base_res = a_q | b_q;
      OP_AND:  base_res = a_q & b_q;
      OP_SUB:  base_res = a_q - b_q;
      OP_LUI:  base_res = a_q;
      OP_SRA:  base_res = $signed(a_q) >>> shamt;
      default: base_res = '0;
    endcase
  end

  // ---- sign handling ----
  logic a_sgn, b_sgn, a_neg, b_neg;
  logic [N-1:0] mag_a, mag_b;

  assign a_sgn = (mf != M_MULHU) && (mf != M_DIVU)
              && (mf != M_REMU);
  assign b_sgn = a_sgn && (mf != M_MULHSU);
  assign a_neg = a_sgn && a_q[N-1];
  assign b_neg = b_sgn && b_q[N-1];
  assign mag_a = a_neg ? -a_q : a_q;
  assign mag_b = b_neg ? -b_q : b_q;

  // ---- iterative datapath ----
  logic           it_load, it_mode, it_run, it_last;
  logic [2*N-1:0] it_acc;

  // first cycle in MUL/DIV loads, then N step cycles
  assign it_mode = (state == S_DIV);
  assign it_load = ((state == S_MUL) || (state == S_DIV))
                && !it_run;

  iter_muldiv_nb #(.N(N)) u_iter (
    .clk  (CLK),
    .rst  (RST),
    .load (it_load),
    .mode (it_mode),
    .a    (mag_a),
    .b    (mag_b),
    .run  (it_run),
    .last (it_last),
    .acc  (it_acc)
  );

  // ---- FIX stage ----
  logic [2*N-1:0] prod;
  logic [N-1:0]   q_s, r_s, fix_res;
  logic           div0, ovf, zmul;

  assign prod = (a_neg ^ b_neg) ? -it_acc : it_acc;
  assign q_s  = (a_neg ^ b_neg) ? -it_acc[N-1:0]
                                : it_acc[N-1:0];
  assign r_s  = a_neg ? -it_acc[2*N-1:N]
                      : it_acc[2*N-1:N];
  assign div0 = (b_q == '0);
  assign ovf  = (a_q == min_v) && (b_q == '1) && b_sgn;
  assign zmul = (a_q == '0) || (b_q == '0);

  // special cases override the datapath so early-out needs no iterations
  always_comb begin
    fix_res = '0;
    if (!mf[2]) begin
      if (zmul)
        fix_res = '0;
      else if (mf == M_MUL)
        fix_res = prod[N-1:0];
      else
        fix_res = prod[2*N-1:N];
    end else if (div0) begin
      fix_res = mf[1] ? a_q : '1;
    end else if (ovf) begin
      fix_res = mf[1] ? '0 : a_q;
    end else begin
      fix_res = mf[1] ? r_s : q_s;
    end
  end

`ifdef ALU_MC_EARLY_OUT_EN
  function automatic logic early_hit(
    input logic [2:0]   f,
    input logic [N-1:0] a,
    input logic [N-1:0] b
  );
    logic sd;
    sd = (f == M_DIV) || (f == M_REM);
    if (!f[2])
      return (a == '0) || (b == '0);
    return (b == '0)
        || (sd && (a == {1'b1, {(N-1){1'b0}}})
               && (b == '1));
  endfunction
`endif

  // ---- control FSM ----
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= S_IDLE;
      a_q    <= '0;
      b_q    <= '0;
      fun_q  <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            a_q   <= srcA;
            b_q   <= srcB;
            fun_q <= alu_fun;
            busy  <= 1'b1;
            if (!m_op)
              state <= S_BASE;
`ifdef ALU_MC_EARLY_OUT_EN
            else if (early_hit(alu_fun[2:0], srcA, srcB))
              state <= S_FIX;
`endif
            else if (alu_fun[2])
              state <= S_DIV;
            else
              state <= S_MUL;
          end
        end
        S_BASE: begin
          result <= base_res;
          done   <= 1'b1;
          state  <= S_DONE;
        end
        S_MUL, S_DIV: begin
          if (it_last)
            state <= S_FIX;
        end
        S_FIX: begin
          result <= fix_res;
          done   <= 1'b1;
          state  <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc_nb.sv
// Randomised self-checking bench for alu_mc_nb (N=32).
// Honours ALU_MC_EARLY_OUT_EN for expected latencies.
module tb_alu_mc_nb;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        m_op;
  logic [3:0]  alu_fun;
  logic [31:0] srcA, srcB;
  logic [31:0] result;
  logic        busy, done;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  alu_mc_nb #(.N(32)) dut (
    .CLK     (clk),
    .RST     (rst),
    .start   (start),
    .m_op    (m_op),
    .alu_fun (alu_fun),
    .srcA    (srcA),
    .srcB    (srcB),
    .result  (result),
    .busy    (busy),
    .done    (done)
  );

  // ---- reference model ----
  function automatic logic [31:0] ref_res(
    input bit m, input logic [3:0] f,
    input logic [31:0] a, input logic [31:0] b
  );
    logic [63:0] p;
    longint sa, sb;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (!m) begin
      case (f)
        4'd0:  return a + b;
        4'd1:  return a << b[4:0];
        4'd2:  return ($signed(a) < $signed(b)) ? 1 : 0;
        4'd3:  return (a < b) ? 1 : 0;
        4'd4:  return a ^ b;
        4'd5:  return a >> b[4:0];
        4'd6:  return a | b;
        4'd7:  return a & b;
        4'd8:  return a - b;
        4'd9:  return a;
        4'd13: return $signed(a) >>> b[4:0];
        default: return 32'd0;
      endcase
    end
    case (f[2:0])
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(
    input bit m, input logic [3:0] f,
    input logic [31:0] a, input logic [31:0] b
  );
    if (!m) return 2;
`ifdef ALU_MC_EARLY_OUT_EN
    if (!f[2] && (a == 0 || b == 0)) return 2;
    if (f[2] && b == 0) return 2;
    if ((f[2:0] == 3'd4 || f[2:0] == 3'd6)
        && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return 2;
`endif
    return 35;
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // issue one op; returns result and done latency in cycles
  task automatic run_op(
    input bit skip_wait, input bit m, input logic [3:0] f,
    input logic [31:0] a, input logic [31:0] b,
    output logic [31:0] res, output int lat, output bit bok
  );
    if (!skip_wait) @(negedge clk);
    start = 1; m_op = m; alu_fun = f; srcA = a; srcB = b;
    @(negedge clk);
    start = 0; m_op = $urandom; alu_fun = $urandom;
    srcA = $urandom; srcB = $urandom;
    lat = 1; bok = 1;
    while (done !== 1'b1 && lat < 100) begin
      if (busy !== 1'b1) bok = 0;
      @(negedge clk);
      lat++;
    end
    if (busy !== 1'b1) bok = 0;
    res = result;
  endtask

  task automatic do_check(
    input string nm, input bit m, input logic [3:0] f,
    input logic [31:0] a, input logic [31:0] b
  );
    logic [31:0] res, exp;
    int lat, el;
    bit bok;
    exp = ref_res(m, f, a, b);
    el  = exp_lat(m, f, a, b);
    run_op(0, m, f, a, b, res, lat, bok);
    checks++;
    if (res !== exp) begin
      fails++;
      $display("FAIL %s res m=%0d f=%0d a=%h b=%h got %h exp %h",
               nm, m, f, a, b, res, exp);
    end
    checks++;
    if (lat != el) begin
      fails++;
      $display("FAIL %s lat m=%0d f=%0d got %0d exp %0d",
               nm, m, f, lat, el);
    end
    checks++;
    if (!bok) begin
      fails++;
      $display("FAIL %s busy m=%0d f=%0d got low exp high",
               nm, m, f);
    end
  endtask

  task automatic test_reset;
    checks++;
    if (result !== 0 || busy !== 0 || done !== 0) begin
      fails++;
      $display("FAIL reset got r=%h b=%b d=%b exp 0 0 0",
               result, busy, done);
    end
  endtask

  task automatic test_base;
    do_check("add_ovf", 0, 4'd0, 32'h7FFF_FFFF, 32'd1);
    do_check("sra", 0, 4'd13, 32'h8000_0000, 32'h21);
    do_check("slt", 0, 4'd2, 32'hFFFF_FFFF, 32'd1);
    do_check("sltu", 0, 4'd3, 32'hFFFF_FFFF, 32'd1);
    for (int i = 0; i < 24; i++)
      do_check("base_rnd", 0, 4'($urandom_range(0, 15)),
               rnd_opnd(), rnd_opnd());
  endtask

  task automatic test_mul;
    do_check("mulh", 1, 4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_check("mulhu", 1, 4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_check("mul", 1, 4'd0, 32'd7, 32'hFFFF_FFFD);
    for (int i = 0; i < 12; i++)
      do_check("mul_rnd", 1, {1'($urandom), 1'b0, 2'($urandom)},
               rnd_opnd(), rnd_opnd());
  endtask

  task automatic test_div;
    do_check("div", 1, 4'd4, 32'hFFFF_FFF9, 32'd2);
    do_check("rem", 1, 4'd6, 32'hFFFF_FFF9, 32'd2);
    do_check("divu", 1, 4'd5, 32'h8000_0000, 32'hFFFF_FFFF);
    do_check("rem_ovf", 1, 4'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    do_check("div_ovf", 1, 4'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    do_check("div0", 1, 4'd4, 32'd5, 32'd0);
    do_check("remu0", 1, 4'd7, 32'd5, 32'd0);
    for (int i = 0; i < 12; i++)
      do_check("div_rnd", 1, {1'($urandom), 1'b1, 2'($urandom)},
               rnd_opnd(), rnd_opnd());
  endtask

  task automatic test_back_to_back;
    logic [31:0] res, exp, a2, b2;
    int lat, nd;
    bit bok;
    @(negedge clk);
    start = 1; m_op = 1; alu_fun = 4'd4;
    srcA = 32'hFFFF_FF9C; srcB = 32'd7;
    exp = ref_res(1, 4'd4, 32'hFFFF_FF9C, 32'd7);
    lat = 0; nd = 0; res = '0;
    while (nd == 0 && lat < 100) begin
      @(negedge clk);
      lat++;
      if (done === 1'b1) begin
        nd++;
        res = result;
      end
      start = 1; m_op = 1; alu_fun = $urandom;
      srcA = $urandom; srcB = $urandom;
    end
    checks++;
    if (res !== exp || lat != 35) begin
      fails++;
      $display("FAIL b2b_first got %h lat %0d exp %h lat 35",
               res, lat, exp);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL b2b_idle got b=%b d=%b exp 0 0",
               busy, done);
    end
    a2 = $urandom; b2 = $urandom;
    run_op(1, 1, 4'd3, a2, b2, res, lat, bok);
    checks++;
    if (res !== ref_res(1, 4'd3, a2, b2)
        || lat != exp_lat(1, 4'd3, a2, b2) || !bok) begin
      fails++;
      $display("FAIL b2b_second got %h lat %0d exp %h",
               res, lat, ref_res(1, 4'd3, a2, b2));
    end
  endtask

  task automatic test_reset_mid;
    int bad;
    @(negedge clk);
    start = 1; m_op = 1; alu_fun = 4'd0;
    srcA = 32'd123; srcB = 32'd456;
    @(negedge clk);
    start = 0;
    repeat (10) @(negedge clk);
    rst = 1; start = 1; m_op = 0; alu_fun = 4'd0;
    srcA = 32'd1; srcB = 32'd2;
    @(negedge clk);
    rst = 0; start = 0;
    checks++;
    if (busy !== 0 || done !== 0 || result !== 0) begin
      fails++;
      $display("FAIL rst_mid got r=%h b=%b d=%b exp 0 0 0",
               result, busy, done);
    end
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 0 || busy !== 0) bad++;
    end
    checks++;
    if (bad != 0) begin
      fails++;
      $display("FAIL rst_nodone got %0d active cycles exp 0", bad);
    end
    do_check("after_rst", 1, 4'd0, 32'd123, 32'd456);
  endtask

  initial begin
    rst = 1; start = 0; m_op = 0; alu_fun = '0;
    srcA = '0; srcB = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 0;
    test_base();
    test_mul();
    test_div();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
